// File: rtl/fabric_credit_tx_if.sv
// Link bundle for fabric_credit_tx: the upstream valid/ready port, the
// ready-less downstream link, credit return and status.
interface fabric_credit_tx_if #(
    parameter int PW = 32,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          credit_return;
    logic [CW-1:0] credits;
    logic          idle;
    logic          err_credit_ovf;

    // master: the transmitter itself
    modport master (
        input  in_valid, in_data, credit_return,
        output in_ready, out_valid, out_data, credits, idle, err_credit_ovf
    );

    // slave: the environment that feeds beats and returns credits
    modport slave (
        output in_valid, in_data, credit_return,
        input  in_ready, out_valid, out_data, credits, idle, err_credit_ovf
    );
endinterface

// File: rtl/fabric_credit_tx.sv
// Credit-based fabric transmitter: forwards accepted beats with one cycle of
// latency and never sends more beats than the remote FIFO has room for.
module fabric_credit_tx #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    fabric_credit_tx_if.master   link
);
    localparam int PW = DATA_WIDTH + TAG_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CREDITS_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CREDIT_NONE = CW'(32'd0);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "COMP_CREDIT_TX_INVALID_DEPTH");
    end
    if (DATA_WIDTH < 1 || TAG_WIDTH < 0) begin : g_bad_type
        $fatal(1, "COMP_CREDIT_TX_INVALID_TYPE");
    end

    logic [0:0]    state_r;
    logic [0:0]    state_next_s;
    logic [CW-1:0] credits_r;
    logic [CW-1:0] credits_next_s;
    logic          err_r;
    logic          err_next_s;
    logic          out_valid_r;
    logic [PW-1:0] out_data_r;
    logic          in_ready_s;
    logic          accept_s;

    // Readiness comes from registered state only, so it never waits on in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst && (state_r == ST_RUN) && (credits_r != CREDIT_NONE)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = link.in_valid && in_ready_s;

    // Credit bookkeeping; a return with no room left is a protocol error that halts the link.
    always_comb begin
        state_next_s   = state_r;
        credits_next_s = credits_r;
        err_next_s     = err_r;
        if (state_r == ST_RUN) begin
            case ({link.credit_return, accept_s})
                2'b10: begin
                    if (credits_r == CREDITS_MAX) begin
                        err_next_s   = 1'b1;
                        state_next_s = ST_HALT;
                    end else begin
                        credits_next_s = credits_r + CREDIT_ONE;
                    end
                end
                2'b01:   credits_next_s = credits_r - CREDIT_ONE;
                default: credits_next_s = credits_r;
            endcase
        end else begin
            state_next_s   = ST_HALT;
            credits_next_s = credits_r;
        end
    end

    // State, credit and link registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            credits_r   <= CREDITS_MAX;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {PW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            credits_r   <= credits_next_s;
            err_r       <= err_next_s;
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_data_r <= link.in_data;
            end
        end
    end

    assign link.in_ready       = in_ready_s;
    assign link.out_valid      = out_valid_r;
    assign link.out_data       = out_data_r;
    assign link.credits        = credits_r;
    assign link.err_credit_ovf = err_r;
    assign link.idle           = (credits_r == CREDITS_MAX) && !out_valid_r;
endmodule

// File: tb/tb_fabric_credit_tx.sv
// Directed bench for fabric_credit_tx (DEPTH=4, 32 data bits, 4 tag bits);
// forwarded beats are matched against a queue of accepted payloads.
module tb_fabric_credit_tx;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int PW    = DW + TW;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [PW-1:0] exp_q[$];

    fabric_credit_tx_if #(.PW(PW), .CW(CW)) link ();

    fabric_credit_tx #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; exp_acc is the bench's own claim that the current beat is accepted.
    task automatic tick(input logic exp_acc);
        if (exp_acc) exp_q.push_back(link.in_data);
        @(posedge clk);
        #1;
        chk("out_valid", 64'(link.out_valid), 64'(exp_acc));
        if (link.out_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                chk("out_data", 64'(link.out_data), 64'(e));
            end else begin
                chk("sb_pop", 64'(exp_q.size()), 64'd1);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        link.in_valid = 1'b0;
        link.in_data = {PW{1'b0}};
        link.credit_return = 1'b0;

        // T1 reset
        tick(1'b0);
        tick(1'b0);
        chk("rst_credits", 64'(link.credits), 64'd4);
        chk("rst_out_data", 64'(link.out_data), 64'd0);
        chk("rst_idle", 64'(link.idle), 64'd1);
        chk("rst_err", 64'(link.err_credit_ovf), 64'd0);
        chk("rst_in_ready", 64'(link.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("t1_in_ready", 64'(link.in_ready), 64'd1);

        // T2 latency
        link.in_valid = 1'b1;
        link.in_data = {4'hA, 32'hDEADBEEF};
        tick(1'b1);
        link.in_valid = 1'b0;
        chk("t2_credits", 64'(link.credits), 64'd3);
        chk("t2_idle", 64'(link.idle), 64'd0);
        chk("t2_data", 64'(link.out_data), 64'h0A_DEAD_BEEF);
        tick(1'b0);
        chk("t2_hold_data", 64'(link.out_data), 64'h0A_DEAD_BEEF);
        link.credit_return = 1'b1;
        tick(1'b0);
        link.credit_return = 1'b0;
        chk("t2_ret_credits", 64'(link.credits), 64'd4);
        chk("t2_ret_idle", 64'(link.idle), 64'd1);

        // T3 exhaustion
        link.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            link.in_data = {4'(i + 1), 32'h1000_0000 + 32'(i)};
            chk("t3_ready_loop", 64'(link.in_ready), 64'd1);
            tick(1'b1);
        end
        chk("t3_in_ready", 64'(link.in_ready), 64'd0);
        chk("t3_credits", 64'(link.credits), 64'd0);
        link.in_data = {4'hF, 32'hBAD0_BAD0};
        tick(1'b0);
        link.credit_return = 1'b1;
        #1;
        chk("t3_ready_same", 64'(link.in_ready), 64'd0);
        tick(1'b0);
        link.credit_return = 1'b0;
        link.in_valid = 1'b0;
        chk("t3_ready_next", 64'(link.in_ready), 64'd1);
        chk("t3_credits_1", 64'(link.credits), 64'd1);

        // T4 simultaneous accept and return
        link.credit_return = 1'b1;
        tick(1'b0);
        chk("t4_credits_pre", 64'(link.credits), 64'd2);
        link.in_valid = 1'b1;
        link.in_data = {4'h3, 32'h1234_5678};
        tick(1'b1);
        link.in_valid = 1'b0;
        chk("t4_credits", 64'(link.credits), 64'd2);
        tick(1'b0);
        tick(1'b0);
        link.credit_return = 1'b0;
        chk("t4_full", 64'(link.credits), 64'd4);
        link.in_valid = 1'b1;
        link.credit_return = 1'b1;
        link.in_data = {4'h7, 32'h0BAD_CAFE};
        tick(1'b1);
        link.in_valid = 1'b0;
        link.credit_return = 1'b0;
        chk("t4_max_credits", 64'(link.credits), 64'd4);
        chk("t4_max_err", 64'(link.err_credit_ovf), 64'd0);
        chk("t4_max_ready", 64'(link.in_ready), 64'd1);

        // T5 overflow and halt
        tick(1'b0);
        chk("t5_idle", 64'(link.idle), 64'd1);
        link.credit_return = 1'b1;
        tick(1'b0);
        link.credit_return = 1'b0;
        chk("t5_err", 64'(link.err_credit_ovf), 64'd1);
        chk("t5_credits", 64'(link.credits), 64'd4);
        chk("t5_ready", 64'(link.in_ready), 64'd0);
        link.in_valid = 1'b1;
        link.in_data = {4'h1, 32'h5555_AAAA};
        tick(1'b0);
        link.in_valid = 1'b0;
        link.credit_return = 1'b1;
        tick(1'b0);
        link.credit_return = 1'b0;
        chk("t5_halt_err", 64'(link.err_credit_ovf), 64'd1);
        chk("t5_halt_credits", 64'(link.credits), 64'd4);
        chk("t5_halt_ready", 64'(link.in_ready), 64'd0);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        #1;
        chk("t5_rst_err", 64'(link.err_credit_ovf), 64'd0);
        chk("t5_rst_ready", 64'(link.in_ready), 64'd1);

        // T6 reset mid-stream, tag pass-through
        link.in_valid = 1'b1;
        link.in_data = {4'h5, 32'hCAFE_F00D};
        tick(1'b1);
        link.in_valid = 1'b0;
        chk("t6_tag", 64'(link.out_data[35:32]), 64'h5);
        chk("t6_credits_pre", 64'(link.credits), 64'd3);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        chk("t6_credits", 64'(link.credits), 64'd4);
        chk("t6_out_data", 64'(link.out_data), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
